// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte channel among NUM_REQ requesters, with lock/burst/timeout release.
// Latency 1 cycle from accept to out_valid; req_ready follows output slot_free so out_ready stalls propagate combinationally.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int DATA_WIDTH   = 8,
  parameter int MAX_BURST    = 16,
  parameter int LOCK_TIMEOUT = 255
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_lock,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          out_valid,
  output logic [DATA_WIDTH-1:0]         out_data,
  input  logic                          out_ready,
  output logic                          grant_valid,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;
  localparam int IW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q;
  logic [GW-1:0]         grant_id_q;
  logic [GW-1:0]         rr_ptr_q;
  logic [BW-1:0]         burst_cnt_q;
  logic [IW-1:0]         idle_cnt_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;

  logic                  slot_free;
  logic                  g_valid;
  logic                  g_lock;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  accept;
  logic                  burst_hit;
  logic                  timeout_hit;
  logic                  release_now;
  logic                  pick_vld;
  logic [GW-1:0]         pick_id;
  logic [GW-1:0]         next_ptr;

  function automatic int wrap_idx(input int s);
    return (s >= NUM_REQ) ? s - NUM_REQ : s;
  endfunction

  assign slot_free = !out_valid_q || out_ready;
  assign g_valid   = req_valid[grant_id_q];
  assign g_lock    = req_lock[grant_id_q];
  assign g_data    = req_data[grant_id_q*DATA_WIDTH +: DATA_WIDTH];
  assign accept    = (state_q == GRANT) && g_valid && slot_free;

  // Hits are evaluated on the pre-increment count so release lands on the Nth byte / Nth idle cycle.
  assign burst_hit   = (MAX_BURST > 0) && (burst_cnt_q == BW'(MAX_BURST - 1));
  assign timeout_hit = (LOCK_TIMEOUT > 0) && (idle_cnt_q >= IW'(LOCK_TIMEOUT - 1));
  assign release_now = (state_q == GRANT) &&
                       ((accept && (!g_lock || burst_hit)) ||
                        (!g_valid && (!g_lock || timeout_hit)));
  assign next_ptr    = (grant_id_q == GW'(NUM_REQ - 1)) ? '0 : grant_id_q + 1'b1;

  always_comb begin
    req_ready = '0;
    if (state_q == GRANT && slot_free) req_ready[grant_id_q] = 1'b1;
  end

  // Scan highest offset first so the requester nearest rr_ptr overwrites the others.
  always_comb begin
    pick_vld = 1'b0;
    pick_id  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[wrap_idx(int'(rr_ptr_q) + k)]) begin
        pick_vld = 1'b1;
        pick_id  = GW'(wrap_idx(int'(rr_ptr_q) + k));
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
      idle_cnt_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      if (accept) begin
        out_valid_q <= 1'b1;
        out_data_q  <= g_data;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      case (state_q)
        IDLE: begin
          if (pick_vld) begin
            state_q     <= GRANT;
            grant_id_q  <= pick_id;
            burst_cnt_q <= '0;
            idle_cnt_q  <= '0;
          end
        end
        GRANT: begin
          if (accept && burst_cnt_q != '1) burst_cnt_q <= burst_cnt_q + 1'b1;
          if (accept || g_valid) begin
            idle_cnt_q <= '0;
          end else if (g_lock && idle_cnt_q != '1) begin
            idle_cnt_q <= idle_cnt_q + 1'b1;
          end
          if (release_now) begin
            state_q  <= IDLE;
            rr_ptr_q <= next_ptr;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign grant_valid = (state_q == GRANT);
  assign grant_id    = grant_id_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: a vector table for rr/back-to-back/stall behaviour,
// plus hand sequences for async reset, burst limit and lock timeout.
module tb_uart_tx_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_data = '0;
  logic [1:0]  req_lock = '0;
  logic [1:0]  req_ready;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_ready = 1'b0;
  logic        grant_valid;
  logic [0:0]  grant_id;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(
    .NUM_REQ(2), .DATA_WIDTH(8), .MAX_BURST(16), .LOCK_TIMEOUT(255)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data), .req_lock(req_lock), .req_ready(req_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .grant_valid(grant_valid), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0] v;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [1:0] lk;
    logic       ordy;
    logic       e_ov;
    logic [7:0] e_od;
    logic [1:0] e_rdy;
    logic       e_gv;
    logic       e_gid;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic [1:0] v, input logic [7:0] d0, input logic [7:0] d1,
                     input logic [1:0] lk, input logic ordy, input logic e_ov,
                     input logic [7:0] e_od, input logic [1:0] e_rdy, input logic e_gv,
                     input logic e_gid);
    vec_t r;
    r.v = v; r.d0 = d0; r.d1 = d1; r.lk = lk; r.ordy = ordy;
    r.e_ov = e_ov; r.e_od = e_od; r.e_rdy = e_rdy; r.e_gv = e_gv; r.e_gid = e_gid;
    vq.push_back(r);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    req_valid = '0;
    req_data  = '0;
    req_lock  = '0;
    out_ready = 1'b1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive_idle();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  int          n_out;
  int          idx1;
  int          cnt;
  int          leak;
  logic        a0, a1, acc;
  logic [7:0]  got [32];
  int          gcyc [32];
  logic [7:0]  exp_b;

  initial begin
    // Reset state, sampled while reset is held.
    drive_idle();
    #3;
    chk("rst.out_valid", 32'(out_valid), 0);
    chk("rst.req_ready", 32'(req_ready), 0);
    chk("rst.grant_valid", 32'(grant_valid), 0);
    chk("rst.grant_id", 32'(grant_id), 0);
    chk("rst.out_data", 32'(out_data), 0);
    do_reset();

    // Both valid from reset: req0, req1, req0.
    add(2'b11, 8'hA0, 8'hB0, 2'b00, 1'b1, 1'b0, 8'h00, 2'b00, 1'b0, 1'b0);
    add(2'b11, 8'hA0, 8'hB0, 2'b00, 1'b1, 1'b0, 8'h00, 2'b01, 1'b1, 1'b0);
    add(2'b11, 8'hA1, 8'hB0, 2'b00, 1'b1, 1'b1, 8'hA0, 2'b00, 1'b0, 1'b0);
    add(2'b11, 8'hA1, 8'hB0, 2'b00, 1'b1, 1'b0, 8'hA0, 2'b10, 1'b1, 1'b1);
    add(2'b01, 8'hA1, 8'hB0, 2'b00, 1'b1, 1'b1, 8'hB0, 2'b00, 1'b0, 1'b1);
    add(2'b01, 8'hA1, 8'hB0, 2'b00, 1'b1, 1'b0, 8'hB0, 2'b01, 1'b1, 1'b0);
    add(2'b00, 8'hA1, 8'hB0, 2'b00, 1'b1, 1'b1, 8'hA1, 2'b00, 1'b0, 1'b0);
    add(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 8'hA1, 2'b00, 1'b0, 1'b0);
    // Single requester, two unlocked bytes with one IDLE cycle between.
    add(2'b01, 8'h41, 8'h00, 2'b00, 1'b1, 1'b0, 8'hA1, 2'b00, 1'b0, 1'b0);
    add(2'b01, 8'h41, 8'h00, 2'b00, 1'b1, 1'b0, 8'hA1, 2'b01, 1'b1, 1'b0);
    add(2'b01, 8'h42, 8'h00, 2'b00, 1'b1, 1'b1, 8'h41, 2'b00, 1'b0, 1'b0);
    add(2'b01, 8'h42, 8'h00, 2'b00, 1'b1, 1'b0, 8'h41, 2'b01, 1'b1, 1'b0);
    add(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 8'h42, 2'b00, 1'b0, 1'b0);
    add(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 8'h42, 2'b00, 1'b0, 1'b0);
    // Output stall: 0x55 held for 5 cycles, next byte waits.
    add(2'b10, 8'h00, 8'h55, 2'b00, 1'b1, 1'b0, 8'h42, 2'b00, 1'b0, 1'b0);
    add(2'b10, 8'h00, 8'h55, 2'b00, 1'b0, 1'b0, 8'h42, 2'b10, 1'b1, 1'b1);
    add(2'b10, 8'h00, 8'h66, 2'b00, 1'b0, 1'b1, 8'h55, 2'b00, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++)
      add(2'b10, 8'h00, 8'h66, 2'b00, 1'b0, 1'b1, 8'h55, 2'b00, 1'b1, 1'b1);
    add(2'b10, 8'h00, 8'h66, 2'b00, 1'b1, 1'b1, 8'h55, 2'b10, 1'b1, 1'b1);
    add(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b1, 8'h66, 2'b00, 1'b0, 1'b1);
    add(2'b00, 8'h00, 8'h00, 2'b00, 1'b1, 1'b0, 8'h66, 2'b00, 1'b0, 1'b1);

    for (int i = 0; i < vq.size(); i++) begin
      req_valid = vq[i].v;
      req_data  = {vq[i].d1, vq[i].d0};
      req_lock  = vq[i].lk;
      out_ready = vq[i].ordy;
      @(negedge clk);
      chk($sformatf("row%0d.out_valid", i), 32'(out_valid), 32'(vq[i].e_ov));
      chk($sformatf("row%0d.out_data", i), 32'(out_data), 32'(vq[i].e_od));
      chk($sformatf("row%0d.req_ready", i), 32'(req_ready), 32'(vq[i].e_rdy));
      chk($sformatf("row%0d.grant_valid", i), 32'(grant_valid), 32'(vq[i].e_gv));
      chk($sformatf("row%0d.grant_id", i), 32'(grant_id), 32'(vq[i].e_gid));
      @(posedge clk);
      #1;
    end

    // Async reset while a locked grant holds a stalled byte.
    req_valid = 2'b01; req_data = 16'h0077; req_lock = 2'b01; out_ready = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    @(negedge clk);
    chk("mid.grant_valid", 32'(grant_valid), 1);
    chk("mid.out_valid", 32'(out_valid), 1);
    chk("mid.out_data", 32'(out_data), 32'h77);
    out_ready = 1'b1;
    #1;
    chk("mid.req_ready", 32'(req_ready), 32'b01);
    #1;
    reset_n = 1'b0;
    #1;
    chk("arst.out_valid", 32'(out_valid), 0);
    chk("arst.req_ready", 32'(req_ready), 0);
    chk("arst.grant_valid", 32'(grant_valid), 0);
    chk("arst.grant_id", 32'(grant_id), 0);
    chk("arst.out_data", 32'(out_data), 0);
    do_reset();

    // Locked 20-byte message from req1 cut at 16 bytes, req0 slips in one byte.
    n_out = 0; idx1 = 0;
    req_valid[1] = 1'b1; req_data[15:8] = 8'h10; req_lock[1] = 1'b1;
    for (int cyc = 0; cyc < 200 && n_out < 21; cyc++) begin
      if (cyc == 3) begin req_valid[0] = 1'b1; req_data[7:0] = 8'hC0; end
      @(negedge clk);
      if (out_valid && out_ready) begin
        got[n_out] = out_data; gcyc[n_out] = cyc; n_out++;
      end
      a1 = req_valid[1] && req_ready[1];
      a0 = req_valid[0] && req_ready[0];
      @(posedge clk);
      #1;
      if (a1) begin
        idx1++;
        if (idx1 < 20) begin
          req_data[15:8] = 8'(8'h10 + idx1);
          req_lock[1]    = (idx1 < 19);
        end else begin
          req_valid[1] = 1'b0; req_lock[1] = 1'b0;
        end
      end
      if (a0) req_valid[0] = 1'b0;
    end
    chk("burst.count", 32'(n_out), 21);
    for (int i = 0; i < 21 && i < n_out; i++) begin
      exp_b = (i < 16) ? 8'(8'h10 + i) : (i == 16) ? 8'hC0 : 8'(8'h10 + i - 1);
      chk($sformatf("burst.byte%0d", i), 32'(got[i]), 32'(exp_b));
      if (i > 0)
        chk($sformatf("burst.gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), (i == 16 || i == 17) ? 2 : 1);
    end
    do_reset();

    // Lock held with no data: release after 255 idle cycles, then req1.
    req_valid = 2'b01; req_data = 16'h0099; req_lock = 2'b01;
    acc = 1'b0;
    for (int c = 0; c < 10 && !acc; c++) begin
      @(negedge clk);
      acc = req_valid[0] && req_ready[0];
      @(posedge clk);
      #1;
    end
    chk("tmo.first_accept", 32'(acc), 1);
    req_valid = 2'b10; req_data = 16'hAB00; req_lock = 2'b01;
    cnt = 0; leak = 0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!(grant_valid && grant_id == 1'b0)) break;
      cnt++;
      if (req_ready[1]) leak++;
      @(posedge clk);
      #1;
    end
    chk("tmo.idle_cycles", 32'(cnt), 255);
    chk("tmo.no_ready1", 32'(leak), 0);
    chk("tmo.idle_after", 32'(grant_valid), 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("tmo.next_gv", 32'(grant_valid), 1);
    chk("tmo.next_gid", 32'(grant_id), 1);
    chk("tmo.next_rdy", 32'(req_ready), 32'b10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
